// File: rtl/tbox_move_ctrl.sv
// tbox_move_ctrl: debounced 5-button front end, 3x3 cursor and placement sequencing for the TBox board.
// Build macro TBOX_CURSOR_WRAP_EN: cursor wraps at the board edges; undefined, it saturates at 01/11.
//
// state     | meaning
// ST_IDLE   | waiting for a place press; board feedback is checked here
// ST_ISSUE  | set strobe high, row/col show the latched target cell
// ST_SETTLE | one cycle for the board's valid vector to update

module tbox_move_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_place,
   input  logic [8:0] valid,
   input  logic [1:0] game_state,
   output logic [1:0] row,
   output logic [1:0] col,
   output logic       set,
   output logic       move_err,
   output logic       busy
);

   localparam int NUM_BTN = 5;
   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;
   localparam int B_PLACE = 4;

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] sync1_q, sync2_q;
   logic [NUM_BTN-1:0] lvl_q, lvl_d, lvl_prev_q;
   logic [CNT_W-1:0]   cnt_q [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] evt;

   logic [1:0] row_q, row_d, col_q, col_d;
   logic [1:0] lat_row_q, lat_row_d, lat_col_q, lat_col_d;
   logic       err_q, err_d;
   state_t     state_q, state_d;
   logic [3:0] cur_idx;

   assign btn_raw = {btn_place, btn_right, btn_left, btn_down, btn_up};

   function automatic logic [1:0] cur_dec(input logic [1:0] v);
`ifdef TBOX_CURSOR_WRAP_EN
      cur_dec = (v == 2'd1) ? 2'd3 : v - 2'd1;
`else
      cur_dec = (v == 2'd1) ? 2'd1 : v - 2'd1;
`endif
   endfunction

   function automatic logic [1:0] cur_inc(input logic [1:0] v);
`ifdef TBOX_CURSOR_WRAP_EN
      cur_inc = (v == 2'd3) ? 2'd1 : v + 2'd1;
`else
      cur_inc = (v == 2'd3) ? 2'd3 : v + 2'd1;
`endif
   endfunction

   // Level toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      lvl_d = lvl_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != lvl_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               lvl_d[i] = ~lvl_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   assign evt = lvl_q & ~lvl_prev_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (evt[B_UP] && !evt[B_DOWN]) begin
         row_d = cur_dec(row_q);
      end else if (evt[B_DOWN] && !evt[B_UP]) begin
         row_d = cur_inc(row_q);
      end
      if (evt[B_LEFT] && !evt[B_RIGHT]) begin
         col_d = cur_dec(col_q);
      end else if (evt[B_RIGHT] && !evt[B_LEFT]) begin
         col_d = cur_inc(col_q);
      end
   end

   // Target cell uses the cursor before any same-cycle movement.
   assign cur_idx = 4'(({2'b00, row_q} - 4'd1) * 4'd3 + {2'b00, col_q} - 4'd1);

   always_comb begin
      state_d   = state_q;
      err_d     = 1'b0;
      lat_row_d = lat_row_q;
      lat_col_d = lat_col_q;
      case (state_q)
         ST_IDLE: begin
            if (evt[B_PLACE]) begin
               if ((game_state != 2'b00) || valid[cur_idx]) begin
                  err_d = 1'b1;
               end else begin
                  state_d   = ST_ISSUE;
                  lat_row_d = row_q;
                  lat_col_d = col_q;
               end
            end
         end
         ST_ISSUE:  state_d = ST_SETTLE;
         ST_SETTLE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      set      = (state_q == ST_ISSUE);
      busy     = (state_q != ST_IDLE);
      move_err = err_q;
      row      = set ? lat_row_q : row_q;
      col      = set ? lat_col_q : col_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         lvl_q      <= '0;
         lvl_prev_q <= '0;
         cnt_q      <= '{default: '0};
         row_q      <= 2'd1;
         col_q      <= 2'd1;
         lat_row_q  <= 2'd1;
         lat_col_q  <= 2'd1;
         err_q      <= 1'b0;
         state_q    <= ST_IDLE;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_q;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         col_q      <= col_d;
         lat_row_q  <= lat_row_d;
         lat_col_q  <= lat_col_d;
         err_q      <= err_d;
         state_q    <= state_d;
      end
   end

endmodule

// File: doc/tbox_move_ctrl.md
# tbox_move_ctrl

Player-input front end for the tic-tac-toe board. Debounces five raw push-buttons, maintains a 3x3 cursor, and issues single-cycle `set` strobes with `row`/`col` to the board. The board is the downstream TBox stage. The block validates each placement against the board's `valid` and `game_state` feedback and flags rejected moves.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required before a button level change is accepted (>=1).
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_place`  in  1 each  raw asynchronous buttons, active-high.
- `valid`  in  9  occupancy from board, bit i = cell (row-1)*3+(col-1).
- `game_state`  in  2  board status: 00 play, 01 X won, 10 O won, 11 draw.
- `row`  out  2  cursor row, 01..11.
- `col`  out  2  cursor column, 01..11.
- `set`  out  1  one-cycle placement strobe to board.
- `move_err`  out  1  one-cycle pulse: placement rejected.
- `busy`  out  1  high while a placement is in flight (ISSUE or SETTLE).

## Operation
- Input path per button: 2-flop synchronizer, then debounce counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Press event = debounced level 0->1 (registered edge detect). Releases generate nothing.
- Cursor:
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - Same-cycle up+down cancel. Same-cycle left+right cancel.
  - Horizontal and vertical events in one cycle both apply.
  - Edge behaviour per Configuration.
  - `row`/`col` are never 00.
  - Cursor moves are accepted in every FSM state.
- FSM states IDLE, ISSUE, SETTLE:
  - IDLE: on place event, index = cursor value before any same-cycle movement.
    - If `game_state`!=00 or `valid[index]`=1: pulse `move_err` next cycle, stay IDLE.
    - Else: go to ISSUE, latch index.
  - ISSUE: `set`=1 for exactly this cycle. `row`/`col` present the latched index, overriding cursor display this cycle. Go to SETTLE.
  - SETTLE: one cycle for board `valid` to update. Then IDLE.
  - Place events arriving in ISSUE/SETTLE are dropped silently: no `move_err`, no queueing.
- Only one of `set`/`move_err` is high in any cycle.

## Timing
- Reset values: `row`=01, `col`=01, `set`=0, `move_err`=0, `busy`=0, FSM=IDLE, all debounced levels 0, counters 0, synchronizers 0.
- Reset assertion takes effect immediately, mid-placement included. `set` drops without completing.
- Button-to-event latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- Place event in cycle N -> `set` high in N+1 (ISSUE) -> SETTLE N+2 -> IDLE N+3. Next place accepted from N+3.
- Rejected place in cycle N -> `move_err` high in N+1 only.
- `busy` high in ISSUE and SETTLE cycles.
- Board feedback (`valid`, `game_state`) is sampled only in IDLE.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

## Configuration
- `TBOX_CURSOR_WRAP_EN` defined: cursor wraps (row 01 up -> 11, row 11 down -> 01; same for col).
- Not defined: cursor saturates at 01 and 11; out-of-range moves are ignored.

## Test plan
- Reset release, no buttons -> `row`=01, `col`=01, `set`=0, `move_err`=0, `busy`=0 indefinitely.
- DEBOUNCE_CYCLES=4, `btn_right` high for 3 cycles then low -> no cursor change. `btn_right` held 10 cycles -> `col` 01->10 exactly once, 7 cycles after the rise.
- Cursor at (10,11), `valid`=0, `game_state`=00, place press:
  - -> `set` pulses 1 cycle with `row`=10, `col`=11, `busy`=1 for 2 cycles.
  - Second place during `busy` -> dropped, no `set`, no `move_err`.
- Cursor at (01,01), `valid[0]`=1, place -> `move_err` 1 cycle, `set` stays 0. Repeat with `valid`=0, `game_state`=01 -> `move_err` 1 cycle.
- Cursor at (01,01), press up and left in the same cycle:
  - WRAP_EN built -> cursor (11,11).
  - WRAP_EN not built -> stays (01,01).
  - Up+down together -> row unchanged.
- Assert `reset` during ISSUE cycle -> `set` falls immediately, cursor returns to (01,01), FSM IDLE. Post-release place works normally.
